// File: rtl/servo_ramp_pkg.sv
// Shared servo definitions: ramp FSM encoding and the default position/step
// limits that the PWM block is also built against.
package servo_ramp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_DONE = 2'd2
  } ramp_state_e;

  // Full PWM period in position codes, and 1 ms per code at 100 MHz.
  localparam int SERVO_MAX_POS  = 250;
  localparam int SERVO_STEP_DIV = 100000;

  // Width of a counter that holds 0..div-1; never narrower than one bit.
  function automatic int tick_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/servo_ramp_tick.sv
// Step-rate divider: counts 0..STEP_DIV-1 while enabled and flags the
// last count as the step tick.
module ramp_tick
  import servo_ramp_pkg::*;
#(
  parameter int STEP_DIV = SERVO_STEP_DIV
) (
  input  logic Clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              CW   = tick_width(STEP_DIV);
  localparam logic [CW-1:0]   LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/servo_ramp.sv
// Servo position ramp: accepts a target code and walks pos_out toward it one
// code per STEP_DIV cycles, pulsing done on arrival.
module servo_ramp
  import servo_ramp_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_POS  = SERVO_MAX_POS,
  parameter int STEP_DIV = SERVO_STEP_DIV
) (
  input  logic         Clock,
  input  logic         reset,
  input  logic         cmd_valid,
  input  logic [N-1:0] cmd_pos,
  output logic         cmd_ready,
  output logic [N-1:0] pos_out,
  output logic         busy,
  output logic         done
);

  // A MAX_POS beyond the code range saturates at the all-ones code.
  localparam int           MAX_LEGAL = (MAX_POS > (2**N) - 1) ? (2**N) - 1 : MAX_POS;
  localparam logic [N-1:0] MAX_CODE  = N'(MAX_LEGAL);

  ramp_state_e  state, next_state;
  logic [N-1:0] target;
  logic [N-1:0] clamped;
  logic [N-1:0] pos_step;
  logic         accept;
  logic         tick;

  ramp_tick #(
    .STEP_DIV (STEP_DIV)
  ) u_tick (
    .Clock  (Clock),
    .reset  (reset),
    .clear  (accept),
    .enable (busy),
    .tick   (tick)
  );

  always_comb begin
    clamped = (cmd_pos > MAX_CODE) ? MAX_CODE : cmd_pos;
    if (pos_out < target) begin
      pos_step = pos_out + 1'b1;
    end else if (pos_out > target) begin
      pos_step = pos_out - 1'b1;
    end else begin
      pos_step = pos_out;
    end
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block is defaulted before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          next_state = (clamped == pos_out) ? ST_DONE : ST_RAMP;
        end
      end
      ST_RAMP: begin
        busy = 1'b1;
        if (tick && (pos_step == target)) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // pos_out moves only on a tick, so it never sees cmd_* combinationally.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      target  <= '0;
      pos_out <= '0;
    end else begin
      if (accept) begin
        target <= clamped;
      end
      if (busy && tick) begin
        pos_out <= pos_step;
      end
    end
  end

endmodule
